// File: rtl/pack_data_lanes.sv
// Purpose: packs per-lane PIPE beats (8/16/32 bits) into DATA_WIDTH-bit words per lane for the deskew/OS FIFO.
// Latency: 1 cycle from the completing beat to fifo_wr_o/data_o; the output word holds until the next completion.
// Backpressure: none toward PIPE; a word completing while fifo_full_i is high is dropped and overflow_o latches.
//
// Ports: clk_i/rst_i (sync, active-high); phy_link_up_i, lane_reverse_i, pipe_width_i, num_active_lanes_i
// configure packing; data_i/data_valid_i/data_k_i/sync_header_i carry physical-lane beats; fifo_full_i is
// downstream status. data_o/data_valid_o/data_k_o/sync_header_o hold the last word in logical lane order,
// fifo_wr_o strobes a write, overflow_o and misalign_o are sticky error flags.
module pack_data_lanes #(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_NUM_LANES = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  phy_link_up_i,
    input  logic                                  lane_reverse_i,
    input  logic [5:0]                            pipe_width_i,
    input  logic [5:0]                            num_active_lanes_i,
    input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0]   data_i,
    input  logic [MAX_NUM_LANES-1:0]              data_valid_i,
    input  logic [4*MAX_NUM_LANES-1:0]            data_k_i,
    input  logic [2*MAX_NUM_LANES-1:0]            sync_header_i,
    input  logic                                  fifo_full_i,
    output logic [MAX_NUM_LANES*DATA_WIDTH-1:0]   data_o,
    output logic [MAX_NUM_LANES-1:0]              data_valid_o,
    output logic [(DATA_WIDTH/8)*MAX_NUM_LANES-1:0] data_k_o,
    output logic [2*MAX_NUM_LANES-1:0]            sync_header_o,
    output logic                                  fifo_wr_o,
    output logic                                  overflow_o,
    output logic                                  misalign_o
);
    localparam int WB = DATA_WIDTH / 8;
    localparam int CW = $clog2(WB) + 1;

    typedef enum logic {ST_DOWN, ST_FILL} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [5:0]              pw_q;
    logic [5:0]              nal_q;
    logic [DATA_WIDTH-1:0]   acc_q [MAX_NUM_LANES];
    logic [WB-1:0]           k_q   [MAX_NUM_LANES];
    logic [1:0]              sh_q  [MAX_NUM_LANES];

    int                      bpb;
    int                      nal;
    logic                    cfg_legal;
    logic [MAX_NUM_LANES-1:0] active_mask;

    logic                    cfg_chg;
    logic                    fill_ok;
    logic [MAX_NUM_LANES-1:0] lane_vld;
    logic                    beat_acc;
    logic                    beat_mis;
    logic                    word_done;

    logic [DATA_WIDTH-1:0]   merged_dat [MAX_NUM_LANES];
    logic [WB-1:0]           merged_k   [MAX_NUM_LANES];
    logic [1:0]              lane_sh    [MAX_NUM_LANES];

    // Config decode: bytes per beat, legality and the active-lane mask.
    always_comb begin
        bpb = 0;
        case (pipe_width_i)
            6'd8:    bpb = 1;
            6'd16:   bpb = 2;
            6'd32:   bpb = 4;
            default: bpb = 0;
        endcase
        nal = int'(num_active_lanes_i);
        cfg_legal = (bpb != 0) && (int'(pipe_width_i) <= DATA_WIDTH) &&
                    (nal != 0) && (nal <= MAX_NUM_LANES) &&
                    ((num_active_lanes_i & (num_active_lanes_i - 6'd1)) == 6'd0);
        for (int i = 0; i < MAX_NUM_LANES; i++) begin
            active_mask[i] = (i < nal);
        end
    end

    // A width or lane-count change in this very cycle discards the beat and the partial word.
    assign cfg_chg   = (pipe_width_i != pw_q) || (num_active_lanes_i != nal_q);
    assign fill_ok   = (state_q == ST_FILL) && phy_link_up_i && cfg_legal && !cfg_chg;
    assign lane_vld  = data_valid_i & active_mask;
    assign beat_acc  = fill_ok && (lane_vld == active_mask);
    assign beat_mis  = fill_ok && (lane_vld != '0) && (lane_vld != active_mask);
    assign word_done = beat_acc && ((int'(cnt_q) + bpb) >= WB);

    // Accumulator contents with the current beat merged in, per logical lane.
    // A word starting at cnt==0 begins from zero so unwritten bytes read as 0.
    always_comb begin : merge
        int p;
        int off;
        logic [31:0] beat_dat;
        logic [3:0]  beat_k;
        p        = 0;
        off      = 0;
        beat_dat = '0;
        beat_k   = '0;
        for (int l = 0; l < MAX_NUM_LANES; l++) begin
            p = l;
            if (lane_reverse_i && cfg_legal && (l < nal)) begin
                p = nal - 1 - l;
            end
            beat_dat   = data_i[p*DATA_WIDTH +: 32];
            beat_k     = data_k_i[p*4 +: 4];
            lane_sh[l] = sync_header_i[p*2 +: 2];
            merged_dat[l] = (cnt_q == '0) ? '0 : acc_q[l];
            merged_k[l]   = (cnt_q == '0) ? '0 : k_q[l];
            for (int j = 0; j < WB; j++) begin
                off = j - int'(cnt_q);
                if ((off >= 0) && (off < bpb)) begin
                    merged_dat[l][8*j +: 8] = beat_dat[8*off +: 8];
                    merged_k[l][j]          = beat_k[off];
                end
            end
            if (!active_mask[l]) begin
                merged_dat[l] = '0;
                merged_k[l]   = '0;
                lane_sh[l]    = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_DOWN;
            cnt_q         <= '0;
            pw_q          <= '0;
            nal_q         <= '0;
            for (int l = 0; l < MAX_NUM_LANES; l++) begin
                acc_q[l] <= '0;
                k_q[l]   <= '0;
                sh_q[l]  <= '0;
            end
            data_o        <= '0;
            data_valid_o  <= '0;
            data_k_o      <= '0;
            sync_header_o <= '0;
            fifo_wr_o     <= 1'b0;
            overflow_o    <= 1'b0;
            misalign_o    <= 1'b0;
        end else begin
            pw_q      <= pipe_width_i;
            nal_q     <= num_active_lanes_i;
            fifo_wr_o <= 1'b0;

            case (state_q)
                ST_DOWN: if (phy_link_up_i && cfg_legal)    state_q <= ST_FILL;
                ST_FILL: if (!phy_link_up_i || !cfg_legal)  state_q <= ST_DOWN;
                default: state_q <= ST_DOWN;
            endcase

            if (beat_acc) begin
                cnt_q <= word_done ? '0 : cnt_q + CW'(bpb);
            end else if (!fill_ok || beat_mis) begin
                cnt_q <= '0;
            end

            if (beat_acc && !word_done) begin
                for (int l = 0; l < MAX_NUM_LANES; l++) begin
                    acc_q[l] <= merged_dat[l];
                    k_q[l]   <= merged_k[l];
                    if (cnt_q == '0) sh_q[l] <= lane_sh[l];
                end
            end

            // Output registers load even when the word is dropped for fifo_full_i.
            if (word_done) begin
                for (int l = 0; l < MAX_NUM_LANES; l++) begin
                    data_o[l*DATA_WIDTH +: DATA_WIDTH] <= merged_dat[l];
                    data_k_o[l*WB +: WB]               <= merged_k[l];
                    sync_header_o[l*2 +: 2]            <= (cnt_q == '0 || !active_mask[l]) ? lane_sh[l] : sh_q[l];
                end
                data_valid_o <= active_mask;
                if (fifo_full_i) overflow_o <= 1'b1;
                else             fifo_wr_o  <= 1'b1;
            end

            if (beat_mis) misalign_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pack_data_lanes.sv
// Purpose: exercises pack_data_lanes with directed scenarios and random traffic against a byte-queue model.
// Latency: outputs compared 1 time unit after each rising clock edge.
// Backpressure: fifo_full_i driven directly by the bench.
module tb_pack_data_lanes;
    localparam int DW = 32;
    localparam int NL = 16;
    localparam int WB = DW / 8;
    localparam int AW = NL * DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            link;
    logic            rev;
    logic [5:0]      pw;
    logic [5:0]      nal;
    logic [AW-1:0]   din;
    logic [NL-1:0]   vld;
    logic [4*NL-1:0] kin;
    logic [2*NL-1:0] shin;
    logic            full;

    logic [AW-1:0]    dout;
    logic [NL-1:0]    dvld;
    logic [WB*NL-1:0] dk;
    logic [2*NL-1:0]  dsh;
    logic             wr;
    logic             ovf;
    logic             mis;

    pack_data_lanes #(.DATA_WIDTH(DW), .MAX_NUM_LANES(NL)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .phy_link_up_i      (link),
        .lane_reverse_i     (rev),
        .pipe_width_i       (pw),
        .num_active_lanes_i (nal),
        .data_i             (din),
        .data_valid_i       (vld),
        .data_k_i           (kin),
        .sync_header_i      (shin),
        .fifo_full_i        (full),
        .data_o             (dout),
        .data_valid_o       (dvld),
        .data_k_o           (dk),
        .sync_header_o      (dsh),
        .fifo_wr_o          (wr),
        .overflow_o         (ovf),
        .misalign_o         (mis)
    );

    always #5 clk = ~clk;

    // Reference model: expected outputs plus per-logical-lane byte queues.
    logic [AW-1:0]    e_dat;
    logic [NL-1:0]    e_vld;
    logic [WB*NL-1:0] e_k;
    logic [2*NL-1:0]  e_sh;
    logic             e_wr, e_ovf, e_mis;
    bit               m_up;
    int               m_pw, m_nal;
    logic [7:0]       mq   [NL][$];
    bit               mkq  [NL][$];
    logic [1:0]       mhdr [NL];

    int n_checks, n_pass, wr_cnt;

    function automatic logic [NL-1:0] mask_of(input int n);
        logic [NL-1:0] m;
        for (int i = 0; i < NL; i++) m[i] = (i < n);
        return m;
    endfunction

    function automatic bit legal_cfg(input int w, input int n);
        return (w == 8 || w == 16 || w == 32) && (w <= DW) &&
               (n == 1 || n == 2 || n == 4 || n == 8 || n == 16) && (n <= NL);
    endfunction

    task automatic m_clear();
        for (int l = 0; l < NL; l++) begin
            mq[l].delete();
            mkq[l].delete();
        end
    endtask

    task automatic m_reset();
        e_dat = '0; e_vld = '0; e_k = '0; e_sh = '0;
        e_wr = 1'b0; e_ovf = 1'b0; e_mis = 1'b0;
        m_up = 1'b0; m_pw = 0; m_nal = 0;
        m_clear();
    endtask

    task automatic model_step();
        int w, n, bytes, p;
        logic [NL-1:0] m, vm;
        if (rst) begin
            m_reset();
            return;
        end
        w = int'(pw);
        n = int'(nal);
        bytes = w / 8;
        m = mask_of(n);
        e_wr = 1'b0;
        if (m_up && link && legal_cfg(w, n) && w == m_pw && n == m_nal) begin
            vm = vld & m;
            if (vm == m) begin
                for (int l = 0; l < n; l++) begin
                    p = rev ? (n - 1 - l) : l;
                    if (mq[l].size() == 0) mhdr[l] = shin[2*p +: 2];
                    for (int b = 0; b < bytes; b++) begin
                        mq[l].push_back(din[p*DW + 8*b +: 8]);
                        mkq[l].push_back(kin[4*p + b]);
                    end
                end
                if (mq[0].size() >= WB) begin
                    e_dat = '0; e_k = '0; e_sh = '0;
                    for (int l = 0; l < n; l++) begin
                        for (int j = 0; j < WB; j++) begin
                            e_dat[l*DW + 8*j +: 8] = mq[l][j];
                            e_k[l*WB + j]          = mkq[l][j];
                        end
                        e_sh[2*l +: 2] = mhdr[l];
                    end
                    e_vld = m;
                    if (full) e_ovf = 1'b1;
                    else      e_wr  = 1'b1;
                    m_clear();
                end
            end else if (vm != '0) begin
                e_mis = 1'b1;
                m_clear();
            end
        end else begin
            m_clear();
        end
        m_up  = link && legal_cfg(w, n);
        m_pw  = w;
        m_nal = n;
    endtask

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("data_o",        dout, e_dat);
        check("data_valid_o",  dvld, e_vld);
        check("data_k_o",      dk,   e_k);
        check("sync_header_o", dsh,  e_sh);
        check("fifo_wr_o",     wr,   e_wr);
        check("overflow_o",    ovf,  e_ovf);
        check("misalign_o",    mis,  e_mis);
        if (wr === 1'b1) wr_cnt++;
    endtask

    task automatic set_cfg(input int w, input int n, input bit r);
        pw = 6'(w); nal = 6'(n); rev = r;
    endtask

    task automatic lane(input int p, input logic [31:0] v);
        din[p*DW +: 32] = v;
    endtask

    task automatic go();
        vld = mask_of(int'(nal));
        cycle();
        vld = '0;
    endtask

    task automatic idle(input int n);
        vld = '0;
        repeat (n) cycle();
    endtask

    int pw_tab [7] = '{8, 16, 32, 8, 16, 32, 24};
    int nl_tab [7] = '{1, 2, 4, 8, 16, 16, 3};

    initial begin
        int w0;
        int r;
        logic [7:0] kexp;
        rst = 1'b1; link = 1'b0; rev = 1'b0; pw = '0; nal = '0;
        din = '0; vld = '0; kin = '0; shin = '0; full = 1'b0;
        n_checks = 0; n_pass = 0; wr_cnt = 0;
        m_reset();
        cycle(); cycle();
        check("rst_data", dout, '0);
        check("rst_flags", {ovf, mis, wr}, '0);

        rst = 1'b0; link = 1'b1;

        // x1, 8-bit: bytes 11,22,33,44
        set_cfg(8, 1, 0); idle(3);
        w0 = wr_cnt;
        lane(0, 32'h11); go(); lane(0, 32'h22); go();
        lane(0, 32'h33); go(); lane(0, 32'h44); go();
        check("x1_w8_data", dout[31:0], 32'h44332211);
        check("x1_w8_vld",  dvld, 16'h0001);
        check("x1_w8_wr",   wr, 1'b1);
        idle(1);
        check("x1_w8_wr_once", wr_cnt - w0, 1);

        // x4, 16-bit, reversed
        set_cfg(16, 4, 1); idle(3);
        lane(0, 32'hA0A1); lane(1, 32'hB0B1); lane(2, 32'hC0C1); lane(3, 32'hD0D1); go();
        check("x4_rev_mid_wr", wr, 1'b0);
        lane(0, 32'hA2A3); lane(1, 32'hB2B3); lane(2, 32'hC2C3); lane(3, 32'hD2D3); go();
        check("x4_rev_l3", dout[3*DW +: 32], 32'hA2A3A0A1);
        check("x4_rev_l0", dout[31:0],       32'hD2D3D0D1);
        check("x4_rev_l1", dout[DW +: 32],   32'hC2C3C0C1);
        check("x4_rev_vld", dvld, 16'h000F);
        check("x4_rev_wr", wr, 1'b1);

        // x2, 32-bit, continuous beats
        set_cfg(32, 2, 0); idle(3);
        w0 = wr_cnt;
        vld = mask_of(2);
        for (int i = 0; i < 5; i++) begin
            lane(0, $urandom); lane(1, $urandom);
            kin[7:0] = 8'($urandom);
            kexp = kin[7:0];
            cycle();
            check("x2_w32_k", dk[7:0], kexp);
            check("x2_w32_wr", wr, 1'b1);
        end
        idle(1);
        check("x2_w32_count", wr_cnt - w0, 5);
        kin = '0;

        // x1, 8-bit with a link drop mid-word
        set_cfg(8, 1, 0); idle(3);
        lane(0, 32'hAA); go(); lane(0, 32'hBB); go();
        link = 1'b0; idle(1); link = 1'b1; idle(2);
        w0 = wr_cnt;
        for (int b = 1; b <= 4; b++) begin lane(0, 32'(b)); go(); end
        idle(1);
        check("linkdrop_count", wr_cnt - w0, 1);
        check("linkdrop_data", dout[31:0], 32'h04030201);

        // fifo full at completion
        for (int b = 0; b < 3; b++) begin lane(0, 32'(8'h10 + b)); go(); end
        full = 1'b1; lane(0, 32'h13); go(); full = 1'b0;
        check("full_no_wr", wr, 1'b0);
        check("full_ovf", ovf, 1'b1);
        for (int b = 0; b < 4; b++) begin lane(0, 32'(8'h20 + b)); go(); end
        check("after_full_wr", wr, 1'b1);
        check("after_full_data", dout[31:0], 32'h23222120);
        check("ovf_sticky", ovf, 1'b1);

        // x4, 8-bit misaligned beat then a clean word
        set_cfg(8, 4, 0); idle(3);
        for (int p = 0; p < 4; p++) lane(p, 32'hEE);
        vld = 16'h0007; cycle(); vld = '0;
        check("mis_flag", mis, 1'b1);
        check("mis_no_wr", wr, 1'b0);
        for (int b = 0; b < 4; b++) begin
            for (int p = 0; p < 4; p++) lane(p, 32'(p*16 + b));
            go();
        end
        check("mis_clean_l0", dout[31:0],       32'h03020100);
        check("mis_clean_l3", dout[3*DW +: 32], 32'h33323130);
        check("mis_clean_wr", wr, 1'b1);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                set_cfg(pw_tab[$urandom_range(0, 6)], nl_tab[$urandom_range(0, 6)], 1'($urandom_range(0, 1)));
            end
            link = ($urandom_range(0, 99) != 0);
            rst  = ($urandom_range(0, 999) == 0);
            full = ($urandom_range(0, 7) == 0);
            for (int p = 0; p < NL; p++) lane(p, $urandom);
            kin  = {$urandom, $urandom};
            shin = $urandom;
            r = $urandom_range(0, 9);
            if (r < 7)       vld = mask_of(int'(nal)) | NL'($urandom);
            else if (r == 7) vld = NL'($urandom);
            else             vld = '0;
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
